// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types for the memory stage: word width, access FSM
// states and byte-lane enable encodings.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_be;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PTR    = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } mem_state_e;

  localparam lc3b_be BE_NONE = 2'b00;
  localparam lc3b_be BE_LOW  = 2'b01;
  localparam lc3b_be BE_HIGH = 2'b10;
  localparam lc3b_be BE_WORD = 2'b11;

  localparam lc3b_word BUSY_MAX = 16'hFFFF;

  // Sign-extend one byte to a full word.
  function automatic lc3b_word sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for LDB/STB: picks lane enables, replicates store bytes
// onto both lanes and extracts/sign-extends the addressed byte on loads.
module mem_lane_align
  import lc3b_types::*;
(
  input  logic        i_addr_lsb,
  input  logic        i_byte_op,
  input  logic [15:0] i_store_data,
  input  logic [15:0] i_rdata,
  output logic [1:0]  o_byte_enable,
  output logic [15:0] o_wdata,
  output logic [15:0] o_load_data
);

  // Word ops use both lanes untouched; byte ops select the lane by addr[0].
  always_comb begin
    o_byte_enable = BE_WORD;
    o_wdata       = i_store_data;
    o_load_data   = i_rdata;
    if (i_byte_op) begin
      o_byte_enable = i_addr_lsb ? BE_HIGH : BE_LOW;
      o_wdata       = {i_store_data[7:0], i_store_data[7:0]};
      o_load_data   = i_addr_lsb ? sext8(i_rdata[15:8]) : sext8(i_rdata[7:0]);
    end
  end

endmodule

// File: rtl/mem_access.sv
// Memory-stage access controller: runs one handshaked access (two for
// LDI/STI), steers byte lanes and stalls the pipeline until writeback.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | waiting for a valid load/store from EX/MEM
//   S_PTR    | LDI/STI pointer read, response replaces the address
//   S_ACCESS | final data access (read or write)
//   S_DONE   | one-cycle completion, stall released for MEM/WB advance
module mem_access
  import lc3b_types::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_indirect,
  input  logic        i_byte_op,
  input  logic [15:0] i_address,
  input  logic [15:0] i_store_data,
  input  logic        i_dmem_resp,
  input  logic [15:0] i_dmem_rdata,
  output logic        o_dmem_read,
  output logic        o_dmem_write,
  output logic [15:0] o_dmem_address,
  output logic [15:0] o_dmem_wdata,
  output logic [1:0]  o_dmem_byte_enable,
  output logic        o_stall,
  output logic        o_done,
  output logic [15:0] o_load_data,
  output logic [15:0] o_busy_cycles
);

  mem_state_e r_state;
  lc3b_word   r_addr;
  lc3b_word   r_store_data;
  logic       r_is_read;
  logic       r_is_write;
  logic       r_byte;
  lc3b_word   r_load_data;
  lc3b_word   r_busy;

  logic       w_mem_op;
  logic       w_lane_byte;
  lc3b_be     w_be;
  lc3b_word   w_wdata;
  lc3b_word   w_load_ext;

  assign w_mem_op = i_mem_read | i_mem_write;

  // The pointer read is always a full word, so lane steering applies only
  // to the final access.
  assign w_lane_byte = r_byte & (r_state == S_ACCESS);

  mem_lane_align u_align (
    .i_addr_lsb    (r_addr[0]),
    .i_byte_op     (w_lane_byte),
    .i_store_data  (r_store_data),
    .i_rdata       (i_dmem_rdata),
    .o_byte_enable (w_be),
    .o_wdata       (w_wdata),
    .o_load_data   (w_load_ext)
  );

  // Access sequencing and operand/result capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_store_data <= '0;
      r_is_read    <= 1'b0;
      r_is_write   <= 1'b0;
      r_byte       <= 1'b0;
      r_load_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && w_mem_op) begin
            r_addr       <= i_address;
            r_store_data <= i_store_data;
            // read+write together resolves to a plain write
            r_is_read    <= i_mem_read & ~i_mem_write;
            r_is_write   <= i_mem_write;
            r_byte       <= i_byte_op;
            r_state      <= i_indirect ? S_PTR : S_ACCESS;
          end
        end
        S_PTR: begin
          if (i_dmem_resp) begin
            r_addr  <= i_dmem_rdata;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (i_dmem_resp) begin
            if (r_is_read) r_load_data <= w_load_ext;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating count of cycles spent waiting on memory.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy <= '0;
    end else if ((r_state == S_PTR || r_state == S_ACCESS) && r_busy != BUSY_MAX) begin
      r_busy <= r_busy + 16'd1;
    end
  end

  // Memory requests decoded from registered state only, never from resp.
  always_comb begin
    o_dmem_read        = 1'b0;
    o_dmem_write       = 1'b0;
    o_dmem_address     = '0;
    o_dmem_wdata       = '0;
    o_dmem_byte_enable = BE_NONE;
    case (r_state)
      S_PTR: begin
        o_dmem_read        = 1'b1;
        o_dmem_address     = {r_addr[15:1], 1'b0};
        o_dmem_byte_enable = BE_WORD;
      end
      S_ACCESS: begin
        o_dmem_read        = r_is_read;
        o_dmem_write       = r_is_write;
        o_dmem_address     = r_byte ? r_addr : {r_addr[15:1], 1'b0};
        o_dmem_byte_enable = w_be;
        o_dmem_wdata       = w_wdata;
      end
      default: ;
    endcase
  end

  // Stall covers the accepting IDLE cycle and the wait states; DONE lets
  // the MEM/WB latch advance.
  assign o_stall = (r_state == S_PTR) || (r_state == S_ACCESS) ||
                   ((r_state == S_IDLE) && i_start && w_mem_op);
  assign o_done        = (r_state == S_DONE);
  assign o_load_data   = r_load_data;
  assign o_busy_cycles = r_busy;

endmodule
